// File: rtl/fetch_pkg.sv
// Types shared by the instruction-fetch queue and its buffer.
// Pure declarations: no latency, no backpressure.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IMEM_BASE = 32'hBFC0_0000;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; the head is read combinationally (0-cycle read).
// No internal backpressure: a push into a full FIFO is only legal alongside a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_en;

  assign pop_en = pop & (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Issues imem reads for accepted PCs and buffers tagged returns for decode; data visible MEM_LAT+1 cycles after accept.
// fetch_ready drops once buffered + in-flight entries reach DEPTH; a same-cycle pop does not free a credit.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            fetch_req,
  output logic            fetch_ready,
  input  logic            redirect,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_misaligned,
  input  logic            inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = 6;

  logic [MEM_LAT-1:0] lat_vld;
  logic [MEM_LAT-1:0] lat_mis;
  logic [XLEN-1:0]    lat_pc [MEM_LAT];
  logic [CW-1:0]      count;
  logic [OW-1:0]      inflight;
  logic [OW-1:0]      occupancy;
  logic               accept;
  logic               pop;
  fetch_entry_t       ret_dat;
  fetch_entry_t       head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + OW'(lat_vld[i]);
  end

  assign occupancy   = OW'(count) + inflight;
  assign fetch_ready = rst & (occupancy < OW'(DEPTH));
  assign accept      = fetch_req & fetch_ready & ~redirect;
  assign imem_en     = accept;
  assign imem_addr   = {pc_in[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst || redirect) begin
      lat_vld <= '0;
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) lat_vld[i] <= lat_vld[i-1];
      lat_vld[0] <= accept;
    end
  end

  // Tags are qualified by lat_vld, so they shift every cycle without reset.
  always_ff @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      lat_pc[i]  <= lat_pc[i-1];
      lat_mis[i] <= lat_mis[i-1];
    end
    lat_pc[0]  <= pc_in;
    lat_mis[0] <= |pc_in[1:0];
  end

  assign ret_dat.inst       = imem_rdata;
  assign ret_dat.pc         = lat_pc[MEM_LAT-1];
  assign ret_dat.misaligned = lat_mis[MEM_LAT-1];
  assign pop                = inst_ready & inst_valid;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (lat_vld[MEM_LAT-1]),
    .push_dat (ret_dat),
    .pop      (pop),
    .flush    (redirect),
    .head     (head),
    .count    (count)
  );

  assign inst_valid      = (count != '0);
  assign inst            = head.inst;
  assign inst_pc         = head.pc;
  assign inst_misaligned = head.misaligned;

  assert property (@(posedge clk) disable iff (!rst) occupancy <= OW'(DEPTH));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model checked every cycle plus directed literal pins.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  typedef struct {
    logic [31:0] pc;
    int          t;
  } pend_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        fetch_req;
  logic        fetch_ready;
  logic        redirect;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_misaligned;
  logic        inst_ready;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  fetch_entry_t mq[$];
  pend_t        pend[$];

  instr_fetch_queue #(.DEPTH(DEPTH), .MEM_LAT(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .fetch_req       (fetch_req),
    .fetch_ready     (fetch_ready),
    .redirect        (redirect),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_misaligned (inst_misaligned),
    .inst_ready      (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w == IMEM_BASE) return 32'h0050_0093;
    return w ^ 32'hA5A5_1234;
  endfunction

  // Instruction memory: fixed latency, junk on the bus when nothing returns.
  logic [LAT-1:0] mv   = '0;
  logic [31:0]    ma [LAT];
  logic [31:0]    junk = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    mv    <= {mv[LAT-2:0], imem_en};
    ma[0] <= imem_addr;
    for (int i = 1; i < LAT; i++) ma[i] <= ma[i-1];
    junk  <= $urandom;
  end
  assign imem_rdata = mv[LAT-1] ? mem_word(ma[LAT-1]) : junk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    else passes++;
  endtask

  task automatic model_step();
    bit           exp_fr;
    bit           exp_v;
    bit           acc;
    fetch_entry_t e;
    pend_t        p;
    exp_fr = rst && ((mq.size() + pend.size()) < DEPTH);
    chk("fetch_ready", 32'(fetch_ready), 32'(exp_fr));
    acc = fetch_req && exp_fr && !redirect;
    chk("imem_en", 32'(imem_en), 32'(acc));
    if (acc) chk("imem_addr", imem_addr, pc_in & 32'hFFFF_FFFC);
    exp_v = mq.size() != 0;
    chk("inst_valid", 32'(inst_valid), 32'(exp_v));
    if (exp_v) begin
      chk("inst", inst, mq[0].inst);
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst_misaligned", 32'(inst_misaligned), 32'(mq[0].misaligned));
    end
    if (!rst || redirect) begin
      mq.delete();
      pend.delete();
    end else begin
      if (inst_ready && exp_v) void'(mq.pop_front());
      if (pend.size() != 0 && pend[0].t + LAT == cyc) begin
        p = pend.pop_front();
        e.inst       = mem_word(p.pc);
        e.pc         = p.pc;
        e.misaligned = p.pc[1:0] != 2'b00;
        mq.push_back(e);
      end
      if (acc) begin
        p.pc = pc_in;
        p.t  = cyc;
        pend.push_back(p);
      end
    end
    cyc++;
  endtask

  task automatic cyc_begin();
    @(negedge clk);
  endtask

  task automatic cyc_end();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle();
    cyc_begin();
    cyc_end();
  endtask

  task automatic drain();
    fetch_req  = 1'b0;
    inst_ready = 1'b1;
    repeat (LAT + DEPTH + 2) run_cycle();
    inst_ready = 1'b0;
  endtask

  // Returns mid-cycle (after the negedge) so the caller can inspect the head.
  task automatic wait_valid(input string nm, input int lim);
    bit found;
    found = 1'b0;
    for (int k = 0; k < lim; k++) begin
      cyc_begin();
      if (inst_valid) begin
        found = 1'b1;
        break;
      end
      cyc_end();
    end
    if (!found) cyc_begin();
    chk(nm, 32'(found), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          took;
    int          nacc;
    int          npop;
    logic [31:0] nxt;

    rst = 1'b0; fetch_req = 1'b0; pc_in = '0; redirect = 1'b0; inst_ready = 1'b0;
    @(posedge clk);
    #1;
    run_cycle();
    rst = 1'b1;
    cyc_begin();
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_misaligned", 32'(inst_misaligned), 0);
    chk("rst_fetch_ready", 32'(fetch_ready), 1);
    cyc_end();

    // Single fetch: issue at T, data visible at T+LAT+1.
    pc_in = IMEM_BASE; fetch_req = 1'b1;
    cyc_begin();
    chk("t1_imem_en", 32'(imem_en), 1);
    chk("t1_imem_addr", imem_addr, 32'hBFC0_0000);
    cyc_end();
    fetch_req = 1'b0;
    repeat (LAT - 1) run_cycle();
    cyc_begin();
    chk("t1_not_yet_valid", 32'(inst_valid), 0);
    cyc_end();
    cyc_begin();
    chk("t1_valid", 32'(inst_valid), 1);
    chk("t1_inst", inst, 32'h0050_0093);
    chk("t1_inst_pc", inst_pc, 32'hBFC0_0000);
    cyc_end();
    drain();

    // Back-to-back requests with decode stalled: credits run out after DEPTH.
    pc_in = IMEM_BASE; fetch_req = 1'b1; nacc = 0;
    for (int k = 0; k < 8; k++) begin
      cyc_begin();
      if (k == 4) chk("full_ready_low", 32'(fetch_ready), 0);
      took = imem_en;
      nacc += int'(took);
      cyc_end();
      if (took) pc_in += 4;
    end
    chk("full_accepts", 32'(nacc), 4);
    fetch_req = 1'b0; inst_ready = 1'b1;
    cyc_begin();
    chk("pop_cycle_ready", 32'(fetch_ready), 0);
    cyc_end();
    inst_ready = 1'b0;
    cyc_begin();
    chk("after_pop_ready", 32'(fetch_ready), 1);
    cyc_end();
    drain();

    // Redirect with three reads in flight.
    pc_in = 32'hBFC0_0010; fetch_req = 1'b1;
    repeat (3) begin
      cyc_begin(); took = imem_en; cyc_end();
      if (took) pc_in += 4;
    end
    redirect = 1'b1; pc_in = 32'hBFC0_0100;
    cyc_begin();
    chk("redir_no_issue", 32'(imem_en), 0);
    cyc_end();
    redirect = 1'b0;
    cyc_begin();
    chk("redir_target_issue", 32'(imem_en), 1);
    chk("redir_target_addr", imem_addr, 32'hBFC0_0100);
    cyc_end();
    fetch_req = 1'b0;
    wait_valid("redir_wait_valid", 10);
    chk("redir_first_pc", inst_pc, 32'hBFC0_0100);
    cyc_end();
    drain();

    // Misaligned PC.
    pc_in = 32'hBFC0_0006; fetch_req = 1'b1;
    cyc_begin();
    chk("mis_imem_en", 32'(imem_en), 1);
    chk("mis_imem_addr", imem_addr, 32'hBFC0_0004);
    cyc_end();
    fetch_req = 1'b0;
    wait_valid("mis_wait_valid", 10);
    chk("mis_flag", 32'(inst_misaligned), 1);
    chk("mis_inst_pc", inst_pc, 32'hBFC0_0006);
    chk("mis_inst", inst, 32'h1A65_1230);
    cyc_end();
    drain();

    // Reset with two entries buffered and one read still in flight.
    pc_in = 32'hBFC0_0020;
    for (int k = 0; k < 5; k++) begin
      fetch_req = (k != 2 && k != 4);
      cyc_begin(); took = imem_en; cyc_end();
      if (took) pc_in += 4;
    end
    fetch_req = 1'b0; rst = 1'b0;
    run_cycle();
    rst = 1'b1;
    cyc_begin();
    chk("midrst_valid", 32'(inst_valid), 0);
    chk("midrst_ready", 32'(fetch_ready), 1);
    cyc_end();
    repeat (LAT) begin
      cyc_begin();
      chk("midrst_late_ignored", 32'(inst_valid), 0);
      cyc_end();
    end

    // Streaming: fill, then pop continuously; PCs must come out in order.
    pc_in = 32'hBFC0_0200; nxt = pc_in; nacc = 0; npop = 0;
    for (int k = 0; k < 60; k++) begin
      inst_ready = (k >= 8);
      fetch_req  = (k < 40);
      cyc_begin();
      took = imem_en;
      if (inst_valid && inst_ready) begin
        chk("stream_order", inst_pc, nxt);
        nxt += 4;
        npop++;
      end
      nacc += int'(took);
      cyc_end();
      if (took) pc_in += 4;
    end
    chk("stream_count", 32'(npop), 32'(nacc));
    inst_ready = 1'b0;

    // Random traffic with redirects and occasional resets.
    for (int k = 0; k < 500; k++) begin
      fetch_req  = $urandom_range(0, 3) != 0;
      inst_ready = $urandom_range(0, 2) != 0;
      redirect   = $urandom_range(0, 11) == 0;
      rst        = $urandom_range(0, 79) != 0;
      cyc_begin(); took = imem_en; cyc_end();
      if (redirect)
        pc_in = IMEM_BASE + 32'($urandom_range(0, 255)) * 4 + 32'(($urandom_range(0, 3) == 0) ? 2 : 0);
      else if (took)
        pc_in += 4;
    end
    rst = 1'b1; redirect = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
